adc_apb_poll_master: RTL



---
 rtl/adc_apb_poll_master_pkg.sv | 33 +++
 rtl/adc_apb_poll_master_if.sv | 24 ++
 rtl/adc_apb_poll_master_xfer.sv | 69 ++++++
 rtl/adc_apb_poll_master.sv | 135 +++++++++++++
 4 files changed

// File: rtl/adc_apb_poll_master_pkg.sv
// Shared definitions for the ADC APB poll master: register map, status bits,
// error codes, FSM state encodings and the debug view of both FSMs.
package adc_apb_pkg;

  localparam int SAMPLE_WIDTH = 56;

  // Register map of the ADC FIFO wrapper slave port
  localparam logic [11:0] REG_STATUS  = 12'h000;
  localparam logic [11:0] REG_TRIGGER = 12'h004;
  localparam logic [11:0] REG_HI      = 12'h008;
  localparam logic [11:0] REG_LO      = 12'h00C;

  localparam int STATUS_NONEMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT     = 1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SLVERR  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_POLL, S_RD_HI, S_RD_LO, S_HOLD
  } seq_state_e;

  typedef enum logic [1:0] {
    X_IDLE, X_SETUP, X_ACCESS
  } xfer_state_e;

  typedef struct packed {
    seq_state_e  seq;
    xfer_state_e xfer;
  } dbg_t;

endpackage

// File: rtl/adc_apb_poll_master_if.sv
// APB bus bundle between the poll master and the ADC FIFO wrapper slave port.
interface adc_apb_poll_master_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/adc_apb_poll_master_xfer.sv
// Single APB transfer engine (SETUP then ACCESS until PREADY). A request
// presented on the completing cycle starts the next SETUP back-to-back.
module apb_master_xfer
  import adc_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  slverr,
  output logic                  idle,
  output xfer_state_e           state_o,
  adc_apb_poll_master_if.master apb
);

  xfer_state_e           state, state_nxt;
  logic                  launch;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;

  assign done = (state == X_ACCESS) && apb.PREADY;

  always_comb begin
    state_nxt = state;
    unique case (state)
      X_IDLE:   if (req) state_nxt = X_SETUP;
      X_SETUP:  state_nxt = X_ACCESS;
      X_ACCESS: if (apb.PREADY) state_nxt = req ? X_SETUP : X_IDLE;
      default:  state_nxt = X_IDLE;
    endcase
    launch = req && ((state == X_IDLE) || done);
  end

  // Address/control are captured once at launch so they stay stable until done
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= X_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        paddr_q  <= addr;
        pwrite_q <= write;
        pwdata_q <= wdata;
      end
    end
  end

  assign apb.PSEL    = (state != X_IDLE);
  assign apb.PENABLE = (state == X_ACCESS);
  assign apb.PADDR   = paddr_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;
  assign rdata       = apb.PRDATA;
  assign slverr      = apb.PSLVERR;
  assign idle        = (state == X_IDLE);
  assign state_o     = state;

endmodule

// File: rtl/adc_apb_poll_master.sv
// APB requester for the ADC FIFO wrapper: trigger, poll STATUS, read HI then LO,
// and hand the 56-bit sample to the consumer over a valid/ready stream.
module adc_apb_poll_master
  import adc_apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR  = REG_STATUS,
  parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR = REG_TRIGGER,
  parameter logic [ADDR_WIDTH-1:0] HI_ADDR      = REG_HI,
  parameter logic [ADDR_WIDTH-1:0] LO_ADDR      = REG_LO,
  parameter int                    POLL_LIMIT   = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic [SAMPLE_WIDTH-1:0] sample_o,
  output logic                    sample_valid_o,
  input  logic                    sample_ready_i,
  output logic                    err_o,
  output logic [1:0]              err_code_o,
  output dbg_t                    dbg_o,
  adc_apb_poll_master_if.master   apb
);

  localparam int CNT_W = $clog2(POLL_LIMIT + 1);

  seq_state_e        state, state_nxt;
  xfer_state_e       x_state;
  logic              x_req, x_write, x_done, x_slverr, x_idle;
  logic [ADDR_WIDTH-1:0] x_addr;
  logic [DATA_WIDTH-1:0] x_wdata, x_rdata;
  logic [CNT_W-1:0]  poll_cnt;
  logic              poll_last, poll_timeout;
  logic [SAMPLE_WIDTH-1:0] sample_q;
  logic              valid_q, err_q;
  logic [1:0]        err_code_q;

  apb_master_xfer #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_xfer (
    .PCLK(PCLK), .PRESET(PRESET), .req(x_req), .addr(x_addr), .write(x_write),
    .wdata(x_wdata), .done(x_done), .rdata(x_rdata), .slverr(x_slverr),
    .idle(x_idle), .state_o(x_state), .apb(apb)
  );

  assign poll_last = (poll_cnt >= CNT_W'(POLL_LIMIT - 1));

  always_comb begin
    state_nxt    = state;
    poll_timeout = 1'b0;
    unique case (state)
      S_IDLE:  if (start_i) state_nxt = S_TRIG;
      S_TRIG:  if (x_done) state_nxt = x_slverr ? S_IDLE : S_POLL;
      S_POLL: begin
        if (x_done) begin
          if (x_slverr) state_nxt = S_IDLE;
          else if (x_rdata[STATUS_NONEMPTY_BIT]) state_nxt = S_RD_HI;
          else if (poll_last) begin
            state_nxt    = S_IDLE;
            poll_timeout = 1'b1;
          end
        end
      end
      S_RD_HI: if (x_done) state_nxt = x_slverr ? S_IDLE : S_RD_LO;
      S_RD_LO: if (x_done) state_nxt = x_slverr ? S_IDLE : S_HOLD;
      S_HOLD:  if (sample_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // The transfer to launch is the one belonging to the state being entered,
    // which lets the next SETUP follow the completing ACCESS directly.
    x_req = ((state == S_TRIG) && x_idle) ||
            (x_done && ((state_nxt == S_POLL) || (state_nxt == S_RD_HI) ||
                        (state_nxt == S_RD_LO)));
    x_addr  = STATUS_ADDR;
    x_write = 1'b0;
    x_wdata = '0;
    case (state_nxt)
      S_TRIG: begin
        x_addr  = TRIGGER_ADDR;
        x_write = 1'b1;
        x_wdata = DATA_WIDTH'(1);
      end
      S_RD_HI: x_addr = HI_ADDR;
      S_RD_LO: x_addr = LO_ADDR;
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= S_IDLE;
      poll_cnt   <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && start_i) begin
        poll_cnt   <= '0;
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
      end
      if (x_done) begin
        if (x_slverr) begin
          err_q      <= 1'b1;
          err_code_q <= ERR_SLVERR;
        end else if ((state == S_POLL) && !x_rdata[STATUS_NONEMPTY_BIT]) begin
          if (poll_cnt != '1) poll_cnt <= poll_cnt + 1'b1;
        end else if (state == S_RD_HI) begin
          sample_q[SAMPLE_WIDTH-1:24] <= x_rdata[31:0];
        end else if (state == S_RD_LO) begin
          sample_q[23:0] <= x_rdata[23:0];
          valid_q        <= 1'b1;
        end
      end
      if (poll_timeout) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
      end
      if ((state == S_HOLD) && sample_ready_i) valid_q <= 1'b0;
    end
  end

  // Stream handshake: sample_o is held stable while sample_valid_o=1 and the
  // sample is consumed on the rising edge where valid and ready are both 1.
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = (state != S_IDLE);
  assign err_o          = err_q;
  assign err_code_o     = err_code_q;
  assign dbg_o          = '{seq: state, xfer: x_state};

endmodule
